// File: rtl/hazard_pkg.sv
// Shared types and helpers for the multicycle pipeline hazard controller.
package hazard_pkg;

  // Occupancy FSM: RUN = E flows normally, BUSY = multicycle MDU op holds E.
  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_t;

  // Operand source select for the E-stage ALU inputs.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Width of the BUSY down-counter; it only ever holds MDU_LATENCY-2.
  function automatic int unsigned mdu_cnt_width(input int unsigned latency);
    if (latency < 3) return 1;
    return $clog2(latency - 1);
  endfunction

endpackage

// File: rtl/hazard_fwd.sv
// Forwarding select for one E-stage source operand (M has priority over W).
module hazard_fwd
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              regwrite_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              regwrite_w_i,
  output logic [1:0]        fwd_o
);

  // x0 is hardwired zero, so it is never a forwarding source.
  always_comb begin
    fwd_o = FWD_RF;
    if (rs_e_i != '0 && regwrite_m_i && rs_e_i == rd_m_i) begin
      fwd_o = FWD_M;
    end else if (rs_e_i != '0 && regwrite_w_i && rs_e_i == rd_w_i) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage core: forwarding, load-use stall,
// branch flush, multicycle MDU occupancy, dmem wait states, stall counter.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [1:0]        resultsrcE,
  input  logic              pcsrcE,
  input  logic              mduE,
  input  logic [REG_AW-1:0] rdM,
  input  logic              regwriteM,
  input  logic              memreqM,
  input  logic              dmem_ready,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regwriteW,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              mdu_done,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned CW        = mdu_cnt_width(MDU_LATENCY);
  localparam bit          MDU_MULTI = (MDU_LATENCY > 1);
  localparam logic [CW-1:0] CNT_LOAD =
    CW'((MDU_LATENCY >= 2) ? (MDU_LATENCY - 2) : 0);

  hz_state_t         state_q;
  logic [CW-1:0]     cnt_q;
  logic [CNT_W-1:0]  stall_cycles_q;
  logic [CNT_W-1:0]  stall_cycles_d;

  logic              lwstall;
  logic              memwait;
  logic              busy_hold;
  logic              mdu_fin;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              unused_resultsrc;

  assign unused_resultsrc = resultsrcE[1];

  assign lwstall   = resultsrcE[0] && (rdE != '0) && (rs1D == rdE || rs2D == rdE);
  assign memwait   = memreqM && !dmem_ready;
  assign busy_hold = (state_q == HZ_BUSY) && (cnt_q != '0);
  // MDU result completes: single-cycle op in RUN, or last BUSY cycle.
  assign mdu_fin   = (state_q == HZ_RUN)  ? (mduE && !MDU_MULTI)
                                          : (cnt_q == '0);

  hazard_fwd #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e_i       (rs1E),
    .rd_m_i       (rdM),
    .regwrite_m_i (regwriteM),
    .rd_w_i       (rdW),
    .regwrite_w_i (regwriteW),
    .fwd_o        (fwd_a)
  );

  hazard_fwd #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e_i       (rs2E),
    .rd_m_i       (rdM),
    .regwrite_m_i (regwriteM),
    .rd_w_i       (rdW),
    .regwrite_w_i (regwriteW),
    .fwd_o        (fwd_b)
  );

  // MDU occupancy FSM; frozen entirely while data memory is waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else if (!memwait) begin
      unique case (state_q)
        HZ_RUN: begin
          if (mduE && MDU_MULTI) begin
            state_q <= HZ_BUSY;
            cnt_q   <= CNT_LOAD;
          end
        end
        HZ_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= HZ_RUN;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= HZ_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Prioritised stage enables/clears: reset > memwait > MDU freeze > load-use/branch.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    flushW    = 1'b0;
    forwardAE = fwd_a;
    forwardBE = fwd_b;
    mdu_done  = 1'b0;
    if (reset) begin
      flushD    = 1'b1;
      flushE    = 1'b1;
      flushM    = 1'b1;
      flushW    = 1'b1;
      forwardAE = FWD_RF;
      forwardBE = FWD_RF;
    end else if (memwait) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (busy_hold) begin
      // E is frozen, so a pending load-use or branch is re-evaluated later.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else begin
      mdu_done = mdu_fin;
      if (lwstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
      if (pcsrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // Saturating count of fetch-stall cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stallF && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // Performance counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc (MDU_LATENCY=4, CNT_W=4).
module tb_hazard_ctrl_mc;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;

  // Control vector: {sF,sD,sE,sM,fD,fE,fM,fW,fwdA[1:0],fwdB[1:0],done}
  localparam logic [12:0] IDLE = 13'b0000_0000_00_00_0;
  localparam logic [12:0] RST  = 13'b0000_1111_00_00_0;
  localparam logic [12:0] FRZ  = 13'b1110_0010_00_00_0;
  localparam logic [12:0] MW   = 13'b1111_0001_00_00_0;
  localparam logic [12:0] LW   = 13'b1100_0100_00_00_0;
  localparam logic [12:0] BR   = 13'b0000_1100_00_00_0;
  localparam logic [12:0] LWBR = 13'b1100_1100_00_00_0;
  localparam logic [12:0] DONE = 13'b0000_0000_00_00_1;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0]        resultsrcE;
  logic              pcsrcE, mduE, regwriteM, memreqM, dmem_ready, regwriteW;
  logic              stallF, stallD, stallE, stallM;
  logic              flushD, flushE, flushM, flushW;
  logic [1:0]        forwardAE, forwardBE;
  logic              mdu_done;
  logic [CNT_W-1:0]  stall_cycles;

  int          tests = 0;
  int          fails = 0;
  logic [12:0] exp_q[$];
  logic [12:0] got, exp_v;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_AW(REG_AW), .MDU_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .resultsrcE(resultsrcE), .pcsrcE(pcsrcE), .mduE(mduE),
    .rdM(rdM), .regwriteM(regwriteM), .memreqM(memreqM), .dmem_ready(dmem_ready),
    .rdW(rdW), .regwriteW(regwriteW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mdu_done(mdu_done), .stall_cycles(stall_cycles)
  );

  function automatic logic [12:0] ctl_now();
    return {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
            forwardAE, forwardBE, mdu_done};
  endfunction

  task automatic idle();
    reset = 1'b0; rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0;
    rdM = '0; rdW = '0; resultsrcE = 2'b00; pcsrcE = 1'b0; mduE = 1'b0;
    regwriteM = 1'b0; memreqM = 1'b0; dmem_ready = 1'b1; regwriteW = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; rs1E = 5'd5; rdM = 5'd5; regwriteM = 1'b1;
    memreqM = 1'b1; dmem_ready = 1'b0; mduE = 1'b1;
    exp_q.push_back(RST);
    @(negedge clk);
    got = ctl_now(); exp_v = exp_q.pop_front(); tests++;
    if (got !== exp_v) begin
      fails++; $display("FAIL reset_ctl: got %b expected %b", got, exp_v);
    end
    @(posedge clk); #1;
    tests++;
    if (stall_cycles !== '0) begin
      fails++; $display("FAIL reset_cnt: got %0d expected 0", stall_cycles);
    end
    reset = 1'b0;
  endtask

  task automatic test_forward();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin rs1E = 5'd5; rs2E = 5'd0; rdM = 5'd5; regwriteM = 1'b1;
                 rdW = 5'd5; regwriteW = 1'b1;
                 exp_q.push_back({IDLE[12:5], 2'b10, 2'b00, 1'b0}); end
        1: begin regwriteM = 1'b0;
                 exp_q.push_back({IDLE[12:5], 2'b01, 2'b00, 1'b0}); end
        2: begin rs1E = 5'd0; rdM = 5'd0; regwriteM = 1'b1; rdW = 5'd0;
                 exp_q.push_back(IDLE); end
        3: begin rs1E = 5'd9; rdM = 5'd9; rs2E = 5'd7; rdW = 5'd7;
                 exp_q.push_back({IDLE[12:5], 2'b10, 2'b01, 1'b0}); end
        default: begin memreqM = 1'b1; dmem_ready = 1'b0;
                 exp_q.push_back({MW[12:5], 2'b10, 2'b01, 1'b0}); end
      endcase
      @(negedge clk);
      got = ctl_now(); exp_v = exp_q.pop_front(); tests++;
      if (got !== exp_v) begin
        fails++; $display("FAIL forward c%0d: got %b expected %b", c, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_loaduse();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin resultsrcE = 2'b01; rdE = 5'd3; rs2D = 5'd3; exp_q.push_back(LW); end
        1: begin rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0; exp_q.push_back(IDLE); end
        default: begin resultsrcE = 2'b00; rdE = 5'd3; rs2D = 5'd3; exp_q.push_back(IDLE); end
      endcase
      @(negedge clk);
      got = ctl_now(); exp_v = exp_q.pop_front(); tests++;
      if (got !== exp_v) begin
        fails++; $display("FAIL loaduse c%0d: got %b expected %b", c, got, exp_v);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (stall_cycles !== 4'd1) begin
      fails++; $display("FAIL loaduse_cnt: got %0d expected 1", stall_cycles);
    end
  endtask

  task automatic test_mdu();
    do_reset();
    mduE = 1'b1;
    // Op A: enter, two frozen cycles, done; op B issues back to back.
    for (int c = 0; c < 6; c++) begin
      case (c)
        0, 4:    exp_q.push_back(IDLE);
        3:       exp_q.push_back(DONE);
        default: exp_q.push_back(FRZ);
      endcase
      @(negedge clk);
      got = ctl_now(); exp_v = exp_q.pop_front(); tests++;
      if (got !== exp_v) begin
        fails++; $display("FAIL mdu c%0d: got %b expected %b", c, got, exp_v);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (stall_cycles !== 4'd3) begin
      fails++; $display("FAIL mdu_cnt: got %0d expected 3", stall_cycles);
    end
  endtask

  task automatic test_mdu_memwait();
    do_reset();
    mduE = 1'b1;
    for (int c = 0; c < 7; c++) begin
      memreqM = (c == 2 || c == 3); dmem_ready = !(c == 2 || c == 3);
      if (c == 6) mduE = 1'b0;
      case (c)
        0, 6:    exp_q.push_back(IDLE);
        2, 3:    exp_q.push_back(MW);
        5:       exp_q.push_back(DONE);
        default: exp_q.push_back(FRZ);
      endcase
      @(negedge clk);
      got = ctl_now(); exp_v = exp_q.pop_front(); tests++;
      if (got !== exp_v) begin
        fails++; $display("FAIL mdu_memwait c%0d: got %b expected %b", c, got, exp_v);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (stall_cycles !== 4'd4) begin
      fails++; $display("FAIL mdu_memwait_cnt: got %0d expected 4", stall_cycles);
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle();
      case (c)
        0: begin resultsrcE = 2'b01; rdE = 5'd3; rs1D = 5'd3; pcsrcE = 1'b1;
                 exp_q.push_back(LWBR); end
        1: exp_q.push_back(IDLE);
        2: begin pcsrcE = 1'b1; exp_q.push_back(BR); end
        3: begin mduE = 1'b1; exp_q.push_back(IDLE); end
        4: begin mduE = 1'b1; pcsrcE = 1'b1; resultsrcE = 2'b01; rdE = 5'd3;
                 rs1D = 5'd3; exp_q.push_back(FRZ); end
        5: begin mduE = 1'b1; exp_q.push_back(FRZ); end
        default: begin mduE = 1'b1; pcsrcE = 1'b1; exp_q.push_back(DONE | BR); end
      endcase
      @(negedge clk);
      got = ctl_now(); exp_v = exp_q.pop_front(); tests++;
      if (got !== exp_v) begin
        fails++; $display("FAIL branch c%0d: got %b expected %b", c, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      mduE  = (c < 3);
      reset = (c == 2);
      case (c)
        1:       exp_q.push_back(FRZ);
        2:       exp_q.push_back(RST);
        default: exp_q.push_back(IDLE);
      endcase
      @(negedge clk);
      got = ctl_now(); exp_v = exp_q.pop_front(); tests++;
      if (got !== exp_v) begin
        fails++; $display("FAIL reset_busy c%0d: got %b expected %b", c, got, exp_v);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (stall_cycles !== 4'd0) begin
      fails++; $display("FAIL reset_busy_cnt: got %0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    memreqM = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      exp_q.push_back(MW);
      @(negedge clk);
      got = ctl_now(); exp_v = exp_q.pop_front(); tests++;
      if (got !== exp_v) begin
        fails++; $display("FAIL saturate c%0d: got %b expected %b", c, got, exp_v);
      end
      @(posedge clk); #1;
      if (c == 13) begin
        tests++;
        if (stall_cycles !== 4'd14) begin
          fails++; $display("FAIL saturate_mid: got %0d expected 14", stall_cycles);
        end
      end
    end
    tests++;
    if (stall_cycles !== 4'd15) begin
      fails++; $display("FAIL saturate_cnt: got %0d expected 15", stall_cycles);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_forward();
    test_loaduse();
    test_mdu();
    test_mdu_memwait();
    test_branch();
    test_reset_busy();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
